// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 timing engine.
// State encoding, default timings and LCD register bit positions.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_e;

    localparam int DEF_T_PWRUP = 750000;
    localparam int DEF_T_SETUP = 3;
    localparam int DEF_T_PW    = 25;
    localparam int DEF_T_HOLD  = 2;
    localparam int DEF_T_EXEC  = 2000;
    localparam int DEF_T_CLR   = 82000;

    localparam int LCD_ON = 31;
    localparam int LCD_EN = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    // Clear display and return home need the long execution wait.
    function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Shared down-counter for all FSM dwell times.
// Reloads on i_load; o_done flags the last cycle of a dwell.
module lcd_timer #(
    parameter int CNT_W   = 20,
    parameter int RST_VAL = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_done
);

    logic [CNT_W-1:0] count;

    // Reset value doubles as the power-up load, since reset enters PWRUP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= CNT_W'(RST_VAL);
        end else if (i_load) begin
            count <= i_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_done = (count == CNT_W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 timing engine fed by the core LCD register.
// Captures EN rising edges into a one-entry slot and sequences each command.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = DEF_T_PWRUP,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PW    = DEF_T_PW,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_EXEC  = DEF_T_EXEC,
    parameter int T_CLR   = DEF_T_CLR,
    parameter int CNT_W   = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);

    lcd_state_e       state;
    logic             en_q;
    logic             slot_valid;
    logic             slot_rs;
    logic [7:0]       slot_data;
    logic             capture;
    logic             consume;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             done;
    logic [19:0]      unused_bits;

    assign unused_bits = i_lcd_reg[30:11];

    assign capture = i_lcd_reg[LCD_EN] && !en_q &&
                     i_lcd_reg[LCD_ON] && !i_lcd_reg[LCD_RW];
    assign consume = (state == ST_IDLE) && slot_valid;

    lcd_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_PWRUP)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (load),
        .i_val   (load_val),
        .o_done  (done)
    );

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        unique case (state)
            ST_IDLE: begin
                load     = slot_valid;
                load_val = CNT_W'(T_SETUP);
            end
            ST_SETUP: begin
                load     = done;
                load_val = CNT_W'(T_PW);
            end
            ST_PULSE: begin
                load     = done;
                load_val = CNT_W'(T_HOLD);
            end
            ST_HOLD: begin
                load     = done;
                load_val = is_clr_home(o_lcd_rs, o_lcd_data) ?
                           CNT_W'(T_CLR) : CNT_W'(T_EXEC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q     <= 1'b0;
            o_lcd_on <= 1'b0;
        end else begin
            en_q     <= i_lcd_reg[LCD_EN];
            o_lcd_on <= i_lcd_reg[LCD_ON];
        end
    end

    // A capture may refill the slot in the same cycle IDLE drains it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_valid <= 1'b0;
            slot_rs    <= 1'b0;
            slot_data  <= 8'h00;
            o_overrun  <= 1'b0;
        end else if (capture && (!slot_valid || consume)) begin
            slot_valid <= 1'b1;
            slot_rs    <= i_lcd_reg[LCD_RS];
            slot_data  <= i_lcd_reg[7:0];
        end else if (capture) begin
            o_overrun  <= 1'b1;
        end else if (consume) begin
            slot_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_PWRUP;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_en   <= 1'b0;
        end else begin
            unique case (state)
                ST_PWRUP: if (done) state <= ST_IDLE;
                ST_IDLE: begin
                    if (slot_valid) begin
                        o_lcd_rs   <= slot_rs;
                        o_lcd_data <= slot_data;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (done) begin
                        o_lcd_en <= 1'b1;
                        state    <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (done) begin
                        o_lcd_en <= 1'b0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: if (done) state <= ST_EXEC;
                ST_EXEC: if (done) state <= ST_IDLE;
                default: state <= ST_PWRUP;
            endcase
        end
    end

    assign o_lcd_rw = 1'b0;
    assign o_busy   = (state != ST_IDLE) || slot_valid;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a cycle-indexed command model predicts
// EN pulses and busy/overrun/on levels; a monitor compares them.
module tb_lcd_ctrl;

    localparam int T_PWRUP = 10;
    localparam int T_SETUP = 3;
    localparam int T_PW    = 5;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 20;
    localparam int T_CLR   = 50;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_reg = 32'h0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    exp_t exp_q[$];

    logic       m_prev_en = 1'b0;
    logic       m_slot = 1'b0;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovr = 1'b0;
    logic       m_on = 1'b0;
    int         m_ready = T_PWRUP + 1;

    lcd_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_PW    (T_PW),
        .T_HOLD  (T_HOLD),
        .T_EXEC  (T_EXEC),
        .T_CLR   (T_CLR),
        .CNT_W   (20)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_lcd_reg  (lcd_reg),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: a command starts at the first edge where it is
    // pending and the engine is free; its whole timeline follows from that.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc       = 0;
            m_prev_en = 1'b0;
            m_slot    = 1'b0;
            m_ovr     = 1'b0;
            m_on      = 1'b0;
            m_ready   = T_PWRUP + 1;
            exp_q.delete();
        end else begin
            cyc++;
            if (m_slot && cyc >= m_ready) begin
                exp_q.push_back('{m_rs, m_data, cyc + T_SETUP});
                m_ready = cyc + T_SETUP + T_PW + T_HOLD + 1 +
                          ((!m_rs && (m_data == 8'h01 || m_data == 8'h02)) ?
                           T_CLR : T_EXEC);
                m_slot = 1'b0;
            end
            if (lcd_reg[10] && !m_prev_en && lcd_reg[31] && !lcd_reg[8]) begin
                if (m_slot) begin
                    m_ovr = 1'b1;
                end else begin
                    m_slot = 1'b1;
                    m_rs   = lcd_reg[9];
                    m_data = lcd_reg[7:0];
                end
            end
            m_prev_en = lcd_reg[10];
            m_on      = lcd_reg[31];
        end
    end

    initial begin : monitor
        logic in_pulse;
        int   rise_cyc;
        exp_t e;
        in_pulse = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pulse = 1'b0;
            end else begin
                chk("busy", busy, (cyc < m_ready - 1) || m_slot);
                chk("overrun", overrun, m_ovr);
                chk("lcd_on", lcd_on, m_on);
                chk("lcd_rw", lcd_rw, 1'b0);
                if (lcd_en && !in_pulse) begin
                    in_pulse = 1'b1;
                    rise_cyc = cyc;
                    pulses++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("en_rise_cycle", cyc, e.rise);
                        chk("pulse_rs", lcd_rs, e.rs);
                        chk("pulse_data", lcd_data, e.data);
                    end
                end else if (!lcd_en && in_pulse) begin
                    in_pulse = 1'b0;
                    chk("en_width", cyc - rise_cyc, T_PW);
                end
            end
        end
    end

    task automatic write_cmd(input logic on, input logic rw, input logic rs,
                             input logic [7:0] d);
        logic [31:0] v;
        v       = $urandom;
        v[31]   = on;
        v[10]   = 1'b0;
        v[9]    = rs;
        v[8]    = rw;
        v[7:0]  = d;
        @(posedge clk); #1 lcd_reg = v;
        @(posedge clk); #1 lcd_reg[10] = 1'b1;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_en(input int lim);
        int k;
        k = 0;
        while (!lcd_en && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("en_timeout", lcd_en, 1'b1);
    endtask

    initial begin : stim
        int         k;
        int         p0;
        logic       on, rw, rs;
        logic [7:0] d;
        int unsigned r;

        #1;
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_on", lcd_on, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_overrun", overrun, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("pwrup_len", k, T_PWRUP);

        @(posedge clk); #1 lcd_reg = 32'h8000_0241;
        @(posedge clk); #1 lcd_reg = 32'h8000_0641;
        @(posedge clk); #1;
        chk("single_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("single_rs", lcd_rs, 1'b1);
        chk("single_data", lcd_data, 8'h41);
        wait_idle(100);

        write_cmd(1'b1, 1'b0, 1'b0, 8'h01);
        k = 0;
        @(posedge clk); #1;
        while (busy && k < 200) begin
            k++;
            @(posedge clk); #1;
        end
        chk("clear_busy_len", k, 1 + T_SETUP + T_PW + T_HOLD + T_CLR);

        p0 = pulses;
        write_cmd(1'b1, 1'b1, 1'b1, 8'h55);
        write_cmd(1'b0, 1'b0, 1'b1, 8'h66);
        repeat (40) @(posedge clk);
        chk("filter_pulses", pulses - p0, 0);
        chk("filter_overrun", overrun, 1'b0);

        p0 = pulses;
        write_cmd(1'b1, 1'b0, 1'b1, 8'h11);
        wait_en(50);
        write_cmd(1'b1, 1'b0, 1'b1, 8'h22);
        write_cmd(1'b1, 1'b0, 1'b1, 8'h33);
        @(posedge clk); #1;
        chk("ovr_set", overrun, 1'b1);
        wait_idle(300);
        chk("ovr_pulses", pulses - p0, 2);
        chk("ovr_sticky", overrun, 1'b1);

        write_cmd(1'b1, 1'b0, 1'b1, 8'h44);
        wait_en(50);
        write_cmd(1'b1, 1'b0, 1'b0, 8'h02);
        @(posedge clk); #2;
        chk("pre_rst_en", lcd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", lcd_en, 1'b0);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_data", lcd_data, 8'h00);
        lcd_reg = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (T_PWRUP + 5) @(posedge clk);
        chk("midrst_slot_lost", pulses - p0, 0);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(99);
            on = 1'b1;
            rw = 1'b0;
            rs = 1'($urandom_range(1));
            d  = 8'($urandom);
            if (r < 10) begin
                rw = 1'b1;
            end else if (r < 20) begin
                on = 1'b0;
            end else if (r < 35) begin
                rs = 1'b0;
                d  = 8'($urandom_range(2, 1));
            end
            write_cmd(on, rw, rs, d);
            repeat ($urandom_range(70)) @(posedge clk);
        end
        wait_idle(500);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: sim did not finish");
        $fatal(1, "timeout");
    end

endmodule
